// File: rtl/popcnt_pkg.sv
// Shared constants and helpers for the popcount result FIFO and its statistics block.
package popcnt_pkg;

    localparam int unsigned STAT_W = 16;
    localparam int unsigned DROP_W = 8;

    function automatic int unsigned cnt_w(input int unsigned data_w);
        return $clog2(data_w + 1);
    endfunction

    function automatic logic [STAT_W-1:0] sat_add(input logic [STAT_W-1:0] a,
                                                  input logic [STAT_W-1:0] b);
        logic [STAT_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[STAT_W] ? '1 : sum[STAT_W-1:0];
    endfunction

endpackage

// File: rtl/popcnt_stats.sv
// Running total (saturating) and maximum of accepted popcount results.
module popcnt_stats
    import popcnt_pkg::*;
#(
    parameter int unsigned CNT_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              push_i,
    input  logic [CNT_W-1:0]  count_i,
    output logic [STAT_W-1:0] total_o,
    output logic [CNT_W-1:0]  max_o
);

    logic [STAT_W-1:0] total_q, total_d;
    logic [CNT_W-1:0]  max_q, max_d;

    // Clear takes priority, so a push coinciding with clear is not counted.
    always_comb begin
        total_d = total_q;
        max_d   = max_q;
        if (clr_i) begin
            total_d = '0;
            max_d   = '0;
        end else if (push_i) begin
            total_d = sat_add(total_q, STAT_W'(count_i));
            if (count_i > max_q) max_d = count_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            total_q <= '0;
            max_q   <= '0;
        end else begin
            total_q <= total_d;
            max_q   <= max_d;
        end
    end

    assign total_o = total_q;
    assign max_o   = max_q;

endmodule

// File: rtl/popcnt_result_fifo.sv
// FWFT result FIFO behind the popcount datapath with drop tracking.
// Statistics logic is built only when POPCNT_STATS_EN is defined.
module popcnt_result_fifo
    import popcnt_pkg::*;
#(
    parameter  int unsigned DATA_W = 8,
    parameter  int unsigned DEPTH  = 4,
    localparam int unsigned CNT_W  = cnt_w(DATA_W),
    localparam int unsigned LVL_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              done_i,
    input  logic [CNT_W-1:0]  count_i,
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic [CNT_W-1:0]  res_data_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [LVL_W-1:0]  level_o,
    output logic              drop_o,
    output logic [DROP_W-1:0] drop_cnt_o,
    input  logic              stat_clr_i,
    output logic [STAT_W-1:0] stat_total_o,
    output logic [CNT_W-1:0]  stat_max_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [CNT_W-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              drop_q, drop_d;
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
    logic              push, pop;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == LVL_W'(DEPTH));
    assign pop     = !empty_o && res_ready_i;
    assign push    = done_i && (!full_o || pop);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        drop_d     = done_i && !push;
        drop_cnt_d = drop_cnt_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
        if (drop_d && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + DROP_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            drop_q     <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            drop_q     <= drop_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage needs no reset: the output mux masks it while empty.
    always_ff @(posedge clk) begin
        if (rst_n && push) mem_q[wr_ptr_q] <= count_i;
    end

    assign res_valid_o = !empty_o;
    assign res_data_o  = empty_o ? '0 : mem_q[rd_ptr_q];
    assign level_o     = level_q;
    assign drop_o      = drop_q;
    assign drop_cnt_o  = drop_cnt_q;

`ifdef POPCNT_STATS_EN
    popcnt_stats #(
        .CNT_W (CNT_W)
    ) u_stats (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (stat_clr_i),
        .push_i  (push),
        .count_i (count_i),
        .total_o (stat_total_o),
        .max_o   (stat_max_o)
    );
`else
    logic unused_stat_clr;
    assign unused_stat_clr = stat_clr_i;
    assign stat_total_o    = '0;
    assign stat_max_o      = '0;
`endif

endmodule
